seat_sched: RTL and testbench
=============================

# seat_sched

Transaction scheduler for the seat table. It arbitrates seat-state change requests from up to four kiosk requesters, round-robin, and serialises them onto the seat table's single read/write port. Each request is a read-check-write sequence that enforces the seat-state transition rules. When requesters are idle, it runs a background sweep that returns expired AWAY seats to FREE.

## Interface
- N_REQ, 4, number of requesters
- N_SEATS, 32, valid seat numbers are 0..N_SEATS-1
- TW, 11, time-stamp width
- clk_sched  in  1  clock
- rst_sched  in  1  asynchronous active-high reset
- req  in  N_REQ  per-requester request level; held until done
- req_seat  in  8*N_REQ  seat number, slice i for requester i
- req_op  in  2*N_REQ  target state, slice i for requester i
- now_time  in  TW  current time
- limit_time  in  TW  AWAY expiry threshold
- gnt  out  N_REQ  one-hot; high for the READ cycle of the granted transaction
- done  out  N_REQ  one-hot, one-cycle completion pulse
- result  out  2  00 OK, 01 DENIED, 10 BADSEAT; valid with done and held until the next done
- busy  out  1  high whenever FSM is not in IDLE
- mem_addr  out  8  seat-table address
- mem_rd  out  1  read strobe; read data is valid the next cycle
- mem_rdata_state  in  2  stored state
- mem_rdata_time  in  TW  stored time stamp
- mem_wr  out  1  write strobe
- mem_wstate  out  2  write state
- mem_wtime  out  TW  write time stamp

## Operation
- Seat states: 0 FREE, 1 AWAY, 2 RESERVED, 3 OCCUPIED.
- Transition rules (current -> target):
  - To OCCUPIED: allowed from FREE, AWAY or RESERVED; denied from OCCUPIED.
  - To AWAY: allowed only from OCCUPIED.
  - To RESERVED: allowed only from FREE.
  - To FREE: always allowed.
- FSM states: IDLE -> READ -> CHECK -> WRITE -> IDLE. All transactions take this path, including denied and BADSEAT ones.
- IDLE, transaction selection:
  - If any req is high, grant the first requester at or after rr_ptr (wrapping). Latch its seat, op, and now_time.
  - Otherwise, start a sweep transaction on sweep_ptr.
  - Forced sweep: after N_REQ consecutive request transactions, the next IDLE runs one sweep even if requests are pending. Running the sweep clears that count.
- READ: assert gnt (request transactions only). Drive mem_addr and mem_rd=1. For BADSEAT (seat >= N_SEATS), mem_rd is suppressed.
- CHECK: sample mem_rdata_state and mem_rdata_time, then evaluate the rules.
  - Sweep transactions compute elapsed = (latched time - stored time) mod 2^TW, an unsigned TW-bit value.
  - A sweep writes only if the stored state is AWAY and elapsed > limit_time (strict).
- WRITE:
  - mem_wr=1 only if the transaction is allowed, with mem_wstate = target state and mem_wtime = latched time.
  - Request transactions pulse done[i] and drive result.
  - Update rr_ptr to (i+1) mod N_REQ after a request transaction.
  - Update sweep_ptr to (ptr+1) mod N_SEATS after a sweep, wrapping 31 -> 0.
- A requester still holding req in the cycle after its done is treated as a new request and arbitrated normally.

## Timing
- Reset values:
  - Outputs: gnt, done, result, mem_rd, mem_wr, mem_addr, mem_wstate, mem_wtime all 0; busy=0.
  - Internal: FSM in IDLE, rr_ptr=0, sweep_ptr=0, consecutive-request count=0.
- Request transaction latency: req sampled in IDLE at edge k; gnt high in cycle k+1; done/result in cycle k+3; FSM back in IDLE at k+4.
- Back-to-back throughput: one transaction per 4 cycles.
- Worst-case wait for a request arriving during a sweep: 3 cycles, plus arbitration.
- A write in WRITE commits at the end of that cycle. The earliest following READ is 2 cycles later, so same-seat back-to-back transactions need no bypass.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; mem_wr and done drop asynchronously.
  - No done is issued for the aborted request; the requester re-arbitrates after reset release.
- mem_rd and mem_wr are never high in the same cycle.

## Test plan
- Reset, then req[0] with seat 5, op OCCUPIED, stored state FREE -> gnt[0] at k+1; mem_wr at k+3 with state 3 and now_time; done[0]; result 00.
- Repeat OCCUPIED on seat 5 -> mem_wr stays 0; result 01 DENIED. Seat 40 -> no mem_rd or mem_wr; result 10 BADSEAT.
- All four req held continuously -> grant order 0,1,2,3, then a sweep, then 0 again; no requester is granted twice before all others.
- Seat 7 AWAY with time 2040, now_time 5, limit 10 (elapsed 13) -> sweep writes FREE at seat 7. The same case with limit 13 -> no write.
- Sweep over idle cycles -> sweep_ptr visits 0..31, then wraps to 0.
- Assert rst_sched during CHECK -> no done, no mem_wr. After release, the held req is re-granted with full 3-cycle latency.

Source files
------------

// File: rtl/seat_sched.sv
// seat_sched: round-robin scheduler for the seat table's single read/write port.
// Each transaction is IDLE -> READ -> CHECK -> WRITE. Request transactions check
// the seat-state transition rules. Sweep transactions return expired AWAY seats
// to FREE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | pick the next transaction (request, or sweep), latch its operands
// S_READ  | gnt and mem_rd are high; the table returns data next cycle
// S_CHECK | stored state/time on mem_rdata_*; decide allow and result
// S_WRITE | mem_wr if allowed; done/result for requests; advance pointers
module seat_sched #(
  parameter int N_REQ   = 4,
  parameter int N_SEATS = 32,
  parameter int TW      = 11
) (
  input  logic                 clk_sched,
  input  logic                 rst_sched,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_seat,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [TW-1:0]        now_time,
  input  logic [TW-1:0]        limit_time,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [1:0]           result,
  output logic                 busy,
  output logic [7:0]           mem_addr,
  output logic                 mem_rd,
  input  logic [1:0]           mem_rdata_state,
  input  logic [TW-1:0]        mem_rdata_time,
  output logic                 mem_wr,
  output logic [1:0]           mem_wstate,
  output logic [TW-1:0]        mem_wtime
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (N_SEATS > 1) ? $clog2(N_SEATS) : 1;
  localparam int CW = $clog2(N_REQ + 1);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_AWAY = 2'd1;
  localparam logic [1:0] ST_RES  = 2'd2;
  localparam logic [1:0] ST_OCC  = 2'd3;

  localparam logic [1:0] RES_OK     = 2'b00;
  localparam logic [1:0] RES_DENIED = 2'b01;
  localparam logic [1:0] RES_BAD    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_WRITE} state_t;

  state_t              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [SW-1:0]       sweep_ptr_q;
  logic [CW-1:0]       cnt_q;
  logic                is_req_q;
  logic [IW-1:0]       idx_q;
  logic [1:0]          op_q;
  logic [TW-1:0]       time_q;
  logic                bad_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic [1:0]          result_q;
  logic [7:0]          mem_addr_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [1:0]          mem_wstate_q;
  logic [TW-1:0]       mem_wtime_q;

  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [N_REQ-1:0]    pick_oh;
  logic [7:0]          pick_seat;
  logic [1:0]          pick_op;
  int                  cand;

  logic                allow;
  logic [1:0]          res;
  logic [TW-1:0]       elapsed;
  logic [N_REQ-1:0]    done_oh;

  // Round-robin pick: first active requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    cand      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (req[IW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
    pick_oh   = '0;
    pick_seat = '0;
    pick_op   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_vld && pick_idx == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_seat  = req_seat[8*i +: 8];
        pick_op    = req_op[2*i +: 2];
      end
    end
  end

  // Rule evaluation on the data returned during CHECK.
  always_comb begin
    allow   = 1'b0;
    res     = RES_OK;
    elapsed = time_q - mem_rdata_time;
    if (is_req_q) begin
      if (bad_q) begin
        res = RES_BAD;
      end else begin
        case (op_q)
          ST_OCC:  allow = (mem_rdata_state != ST_OCC);
          ST_AWAY: allow = (mem_rdata_state == ST_OCC);
          ST_RES:  allow = (mem_rdata_state == ST_FREE);
          default: allow = 1'b1;
        endcase
        res = allow ? RES_OK : RES_DENIED;
      end
    end else begin
      allow = (mem_rdata_state == ST_AWAY) && (elapsed > limit_time);
    end
    done_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_q == IW'(i)) done_oh[i] = 1'b1;
    end
  end

  // Transaction FSM with registered port outputs.
  always_ff @(posedge clk_sched or posedge rst_sched) begin
    if (rst_sched) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      sweep_ptr_q  <= '0;
      cnt_q        <= '0;
      is_req_q     <= 1'b0;
      idx_q        <= '0;
      op_q         <= '0;
      time_q       <= '0;
      bad_q        <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      result_q     <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstate_q <= '0;
      mem_wtime_q  <= '0;
    end else begin
      gnt_q        <= '0;
      done_q       <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstate_q <= '0;
      mem_wtime_q  <= '0;
      case (state_q)
        S_IDLE: begin
          time_q  <= now_time;
          state_q <= S_READ;
          // A full run of N_REQ requests forces one sweep so seats still expire.
          if (pick_vld && cnt_q < CW'(N_REQ)) begin
            cnt_q      <= cnt_q + CW'(1);
            is_req_q   <= 1'b1;
            idx_q      <= pick_idx;
            op_q       <= pick_op;
            bad_q      <= (int'(pick_seat) >= N_SEATS);
            gnt_q      <= pick_oh;
            mem_addr_q <= pick_seat;
            mem_rd_q   <= (int'(pick_seat) < N_SEATS);
          end else begin
            cnt_q      <= '0;
            is_req_q   <= 1'b0;
            op_q       <= ST_FREE;
            bad_q      <= 1'b0;
            mem_addr_q <= 8'(sweep_ptr_q);
            mem_rd_q   <= 1'b1;
          end
        end
        S_READ: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          state_q  <= S_WRITE;
          mem_wr_q <= allow;
          if (allow) begin
            mem_wstate_q <= op_q;
            mem_wtime_q  <= time_q;
          end
          if (is_req_q) begin
            done_q   <= done_oh;
            result_q <= res;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (is_req_q) begin
            rr_ptr_q <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
          end else begin
            sweep_ptr_q <= (sweep_ptr_q == SW'(N_SEATS - 1)) ? '0 : sweep_ptr_q + SW'(1);
          end
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign result     = result_q;
  assign busy       = (state_q != S_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wstate = mem_wstate_q;
  assign mem_wtime  = mem_wtime_q;

endmodule

// File: tb/tb_seat_sched.sv
// Directed bench for seat_sched with a behavioural seat-table model.
module tb_seat_sched;

  logic        clk_sched;
  logic        rst_sched;
  logic [3:0]  req;
  logic [31:0] req_seat;
  logic [7:0]  req_op;
  logic [10:0] now_time;
  logic [10:0] limit_time;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [1:0]  result;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [1:0]  mem_rdata_state;
  logic [10:0] mem_rdata_time;
  logic        mem_wr;
  logic [1:0]  mem_wstate;
  logic [10:0] mem_wtime;

  logic [1:0]  st [32];
  logic [10:0] tm [32];

  int n_total = 0;
  int n_bad   = 0;

  seat_sched dut (
    .clk_sched       (clk_sched),
    .rst_sched       (rst_sched),
    .req             (req),
    .req_seat        (req_seat),
    .req_op          (req_op),
    .now_time        (now_time),
    .limit_time      (limit_time),
    .gnt             (gnt),
    .done            (done),
    .result          (result),
    .busy            (busy),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_rdata_state (mem_rdata_state),
    .mem_rdata_time  (mem_rdata_time),
    .mem_wr          (mem_wr),
    .mem_wstate      (mem_wstate),
    .mem_wtime       (mem_wtime)
  );

  initial begin
    clk_sched = 1'b0;
    forever #5 clk_sched = ~clk_sched;
  end

  // Seat table: read data appears mid-READ, writes land mid-WRITE.
  always @(negedge clk_sched) begin
    if (mem_rd && mem_addr < 8'd32) begin
      mem_rdata_state = st[mem_addr[4:0]];
      mem_rdata_time  = tm[mem_addr[4:0]];
    end
    if (mem_wr && mem_addr < 8'd32) begin
      st[mem_addr[4:0]] = mem_wstate;
      tm[mem_addr[4:0]] = mem_wtime;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sched);
    #1;
  endtask

  // One request transaction on requester i; returns what the WRITE cycle showed.
  task automatic run_req(input int i, input int seat, input logic [1:0] op,
                         output int waited, output logic [1:0] res, output logic wr,
                         output logic [1:0] ws, output logic [10:0] wt);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    req_seat[8*i +: 8] = 8'(seat);
    req_op[2*i +: 2]   = op;
    req[i]             = 1'b1;
    waited = 0;
    res = '0; wr = 1'b0; ws = '0; wt = '0;
    while (gnt == 4'b0 && waited < 40) begin
      tick();
      waited++;
    end
    check_val("gnt_onehot", gnt, oh);
    if (gnt == oh) begin
      check_val("rd_strobe", mem_rd, seat < 32);
      check_val("rd_addr", mem_addr, seat);
      tick();
      tick();
      check_val("done_pulse", done, oh);
      res = result;
      wr  = mem_wr;
      ws  = mem_wstate;
      wt  = mem_wtime;
      req[i] = 1'b0;
      tick();
      check_val("done_clear", done, 0);
    end
    req[i] = 1'b0;
  endtask

  task automatic expect_req(input string tag, input int i, input int seat, input logic [1:0] op,
                            input logic [1:0] exp_res, input logic exp_wr, input logic [1:0] exp_ws);
    int w;
    logic [1:0] r;
    logic wr;
    logic [1:0] ws;
    logic [10:0] wt;
    run_req(i, seat, op, w, r, wr, ws, wt);
    check_val({tag, "_result"}, r, exp_res);
    check_val({tag, "_wr"}, wr, exp_wr);
    if (exp_wr) begin
      check_val({tag, "_wstate"}, ws, exp_ws);
      check_val({tag, "_wtime"}, wt, now_time);
    end
  endtask

  initial begin
    int w;
    int n;
    int nwr;
    logic [1:0] r;
    logic wr;
    logic [1:0] ws;
    logic [10:0] wt;
    logic [3:0] seq [6];
    logic [7:0] wr_addr;
    logic [1:0] wr_st;
    logic [10:0] wr_tm;

    for (int i = 0; i < 32; i++) begin
      st[i] = 2'd0;
      tm[i] = 11'd0;
    end
    mem_rdata_state = 2'd0;
    mem_rdata_time  = 11'd0;
    rst_sched  = 1'b1;
    req        = 4'b0;
    req_seat   = '0;
    req_op     = '0;
    now_time   = 11'd100;
    limit_time = 11'd10;

    // Reset state
    repeat (3) tick();
    check_val("rst_gnt", gnt, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_rd", mem_rd, 0);
    check_val("rst_wr", mem_wr, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_busy", busy, 0);

    // First request straight out of reset: gnt one edge after release
    req_seat[7:0] = 8'd5;
    req_op[1:0]   = 2'd3;
    req[0]        = 1'b1;
    @(negedge clk_sched);
    rst_sched = 1'b0;
    run_req(0, 5, 2'd3, w, r, wr, ws, wt);
    check_val("lat_gnt", w, 1);
    check_val("occ_result", r, 2'b00);
    check_val("occ_wr", wr, 1);
    check_val("occ_wstate", ws, 3);
    check_val("occ_wtime", wt, 100);
    check_val("idle_busy", busy, 0);

    // Transition rules
    expect_req("occ_again", 0, 5, 2'd3, 2'b01, 1'b0, 2'd0);
    expect_req("badseat", 1, 40, 2'd3, 2'b10, 1'b0, 2'd0);
    expect_req("occ_to_away", 3, 5, 2'd1, 2'b00, 1'b1, 2'd1);
    expect_req("away_to_res", 2, 5, 2'd2, 2'b01, 1'b0, 2'd0);
    expect_req("free_to_res", 2, 6, 2'd2, 2'b00, 1'b1, 2'd2);
    expect_req("away_to_free", 0, 5, 2'd0, 2'b00, 1'b1, 2'd0);
    check_val("result_held", result, 2'b00);

    // Round-robin with all requesters held: 0,1,2,3, forced sweep, 0
    rst_sched = 1'b1;
    tick();
    req_seat = {8'd13, 8'd12, 8'd11, 8'd10};
    req_op   = 8'h00;
    req      = 4'hF;
    @(negedge clk_sched);
    rst_sched = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      if (gnt != 4'b0 || mem_rd) begin
        seq[n] = gnt;
        n++;
      end
    end
    req = 4'b0;
    check_val("rr_count", n, 6);
    check_val("rr_0", seq[0], 4'b0001);
    check_val("rr_1", seq[1], 4'b0010);
    check_val("rr_2", seq[2], 4'b0100);
    check_val("rr_3", seq[3], 4'b1000);
    check_val("rr_sweep", seq[4], 4'b0000);
    check_val("rr_wrap", seq[5], 4'b0001);

    // Sweep walk with seat 7 AWAY, elapsed 13 == limit: no write anywhere
    rst_sched = 1'b1;
    tick();
    st[7] = 2'd1;
    tm[7] = 11'd2040;
    now_time   = 11'd5;
    limit_time = 11'd13;
    @(negedge clk_sched);
    rst_sched = 1'b0;
    n = 0;
    nwr = 0;
    for (int c = 0; c < 200 && n < 33; c++) begin
      tick();
      if (mem_rd && gnt == 4'b0) begin
        check_val("sweep_addr", mem_addr, n % 32);
        n++;
      end
      if (mem_wr) nwr++;
    end
    check_val("sweep_count", n, 33);
    check_val("sweep_lim13_wr", nwr, 0);
    check_val("seat7_kept", st[7], 1);

    // Same seat with limit 10: elapsed 13 > 10, seat 7 returns to FREE
    rst_sched = 1'b1;
    tick();
    limit_time = 11'd10;
    @(negedge clk_sched);
    rst_sched = 1'b0;
    nwr = 0;
    wr_addr = '0;
    wr_st = 2'd3;
    wr_tm = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_wr) begin
        nwr++;
        wr_addr = mem_addr;
        wr_st   = mem_wstate;
        wr_tm   = mem_wtime;
      end
    end
    check_val("sweep_lim10_wr", nwr, 1);
    check_val("sweep_wr_addr", wr_addr, 7);
    check_val("sweep_wr_state", wr_st, 0);
    check_val("sweep_wr_time", wr_tm, 5);
    check_val("seat7_freed", st[7], 0);

    // Reset during CHECK: no done, no write; re-grant with full latency
    now_time = 11'd200;
    rst_sched = 1'b1;
    tick();
    req_seat[23:16] = 8'd9;
    req_op[5:4]     = 2'd3;
    req[2]          = 1'b1;
    @(negedge clk_sched);
    rst_sched = 1'b0;
    tick();
    check_val("abort_gnt", gnt, 4'b0100);
    tick();
    rst_sched = 1'b1;
    #1;
    check_val("abort_done", done, 0);
    check_val("abort_wr", mem_wr, 0);
    check_val("abort_busy", busy, 0);
    tick();
    tick();
    check_val("abort_done_late", done, 0);
    check_val("abort_wr_late", mem_wr, 0);
    check_val("abort_seat9", st[9], 0);
    @(negedge clk_sched);
    rst_sched = 1'b0;
    run_req(2, 9, 2'd3, w, r, wr, ws, wt);
    check_val("regrant_lat", w, 1);
    check_val("regrant_result", r, 2'b00);
    check_val("regrant_wr", wr, 1);
    check_val("regrant_wtime", wt, 200);

    // Reset asserted while mem_wr is high drops it without a clock edge
    req_seat[23:16] = 8'd9;
    req_op[5:4]     = 2'd0;
    req[2]          = 1'b1;
    w = 0;
    while (gnt == 4'b0 && w < 40) begin
      tick();
      w++;
    end
    check_val("async_gnt", gnt, 4'b0100);
    tick();
    tick();
    check_val("async_wr_before", mem_wr, 1);
    check_val("async_done_before", done, 4'b0100);
    rst_sched = 1'b1;
    #1;
    check_val("async_wr_drop", mem_wr, 0);
    check_val("async_done_drop", done, 0);
    req = 4'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
